// File: rtl/mem_c_collect.sv
// rtl/mem_c_collect.sv - de-skewing capture buffer for systolic-array result columns
//
// Captures the time-skewed column outputs of a DIM x DIM systolic array into a
// result buffer, then serves whole rows (or columns when
// MEM_C_COLLECT_TRANSPOSE_EN is defined) through a registered read port.
//
// Ports:
//   clk     system clock, all logic on posedge
//   rst     synchronous active-high reset, highest priority
//   start   pulse, begins a capture from IDLE or DONE
//   en      advance strobe shared with the array; capture steps only when high
//   Cin     skewed array outputs, one element per column
//   rd_en   read request, honoured only in DONE
//   Crow    row index to read (column index in transpose mode)
//   Cout    registered read data
//   rd_vld  one-cycle pulse the cycle after an accepted read
//   busy    high while capturing
//   done    high once a full capture is held in the buffer
//
// Optional feature macro: MEM_C_COLLECT_TRANSPOSE_EN (read columns instead of rows)

module mem_c_collect #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     en,
  input  logic signed [BITS_C-1:0] Cin [DIM-1:0],
  input  logic                     rd_en,
  input  logic [$clog2(DIM)-1:0]   Crow,
  output logic signed [BITS_C-1:0] Cout [DIM-1:0],
  output logic                     rd_vld,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(DIM);
  // Counter must reach 2*DIM-2, the last enabled capture cycle.
  localparam int KW = $clog2(2 * DIM);
  localparam logic [KW-1:0] K_LAST = KW'(2 * DIM - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                     state_q;
  logic [KW-1:0]              k_q;
  logic signed [BITS_C-1:0]   mem_q [DIM-1:0][DIM-1:0];

  // Per-column write window: column j carries row k-j while j <= k <= j+DIM-1.
  logic [DIM-1:0]             wr_ok;
  logic [IW-1:0]              wr_row [DIM-1:0];

  for (genvar j = 0; j < DIM; j++) begin : g_win
    assign wr_ok[j]  = (k_q >= KW'(j)) && (k_q <= KW'(j + DIM - 1));
    assign wr_row[j] = IW'(k_q - KW'(j));
  end

  // Read mux; an out-of-range index (only possible for non-power-of-two DIM)
  // returns zeros.
  logic                       crow_ok;
  logic signed [BITS_C-1:0]   rd_data [DIM-1:0];

  assign crow_ok = (int'(Crow) < DIM);

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      rd_data[i] = '0;
      if (crow_ok) begin
`ifdef MEM_C_COLLECT_TRANSPOSE_EN
        rd_data[i] = mem_q[i][Crow];
`else
        rd_data[i] = mem_q[Crow][i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      rd_vld  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        Cout[r] <= '0;
        for (int c = 0; c < DIM; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      rd_vld <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CAPTURE;
            k_q     <= '0;
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          if (en) begin
            for (int j = 0; j < DIM; j++) begin
              if (wr_ok[j]) begin
                mem_q[wr_row[j]][j] <= Cin[j];
              end
            end
            if (k_q == K_LAST) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        DONE: begin
          // A read in the same cycle as start still sees the old buffer,
          // since capture writes begin only after the state change.
          if (rd_en) begin
            Cout   <= rd_data;
            rd_vld <= 1'b1;
          end
          if (start) begin
            state_q <= CAPTURE;
            k_q     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_c_collect.sv
// tb/tb_mem_c_collect.sv - randomized scoreboard bench for mem_c_collect

module tb_mem_c_collect;

  localparam int BITS_C = 24;
  localparam int DIM    = 8;
  localparam int IW     = 3;
  localparam int N      = DIM * BITS_C;
  localparam int NCAP   = 2 * DIM - 1;

  typedef logic [N-1:0] vec_t;

  logic                     clk = 1'b0;
  logic                     rst, start, en, rd_en;
  logic [IW-1:0]            crow;
  logic signed [BITS_C-1:0] cin  [DIM-1:0];
  logic signed [BITS_C-1:0] cout [DIM-1:0];
  logic                     rd_vld, busy, done;

  int   total = 0;
  int   bad   = 0;

  int   mdl_c   [DIM][DIM];
  int   mdl_buf [DIM][DIM];
  bit   mdl_done;
  vec_t exp_q [$];
  vec_t mon_last;
  bit   mon_on = 1'b0;

  mem_c_collect #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .en     (en),
    .Cin    (cin),
    .rd_en  (rd_en),
    .Crow   (crow),
    .Cout   (cout),
    .rd_vld (rd_vld),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t pack_out();
    vec_t v;
    for (int i = 0; i < DIM; i++) v[i*BITS_C +: BITS_C] = cout[i];
    return v;
  endfunction

  function automatic vec_t exp_row(input int sel);
    vec_t v;
    for (int i = 0; i < DIM; i++) begin
`ifdef MEM_C_COLLECT_TRANSPOSE_EN
      v[i*BITS_C +: BITS_C] = BITS_C'(mdl_buf[i][sel]);
`else
      v[i*BITS_C +: BITS_C] = BITS_C'(mdl_buf[sel][i]);
`endif
    end
    return v;
  endfunction

  task automatic check_v(input string nm, input vec_t act, input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: every rd_vld pulse must match the oldest expected read; with no
  // read pending, Cout must hold the last served value.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          check_b("unexpected_rd_vld", rd_vld, 1'b0);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          check_v("read_data", pack_out(), e);
          mon_last = e;
        end
      end else begin
        check_v("cout_hold", pack_out(), mon_last);
      end
    end
  end

  // noisy=1 drives start/en/rd_en high alongside rst to show rst wins.
  task automatic do_reset(input bit noisy);
    rst = 1'b1; start = noisy; en = noisy; rd_en = noisy;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; en = 1'b0; rd_en = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl_buf[r][c] = 0;
    mdl_done = 1'b0;
    exp_q.delete();
    mon_last = '0;
    mon_on   = 1'b1;
    check_b("reset_busy", busy, 1'b0);
    check_b("reset_done", done, 1'b0);
    check_b("reset_rd_vld", rd_vld, 1'b0);
    check_v("reset_cout", pack_out(), '0);
  endtask

  // en_mode: 0 always, 1 alternating, 2 random.
  task automatic do_capture(input int en_mode, input int start_at, input int abort_at,
                            input bit rd_at_start, input bit rd_during);
    int k;
    int clocks;
    bit e;
    k = 0;
    clocks = 0;
    start = 1'b1; en = 1'b0; rd_en = rd_at_start; crow = 2;
    if (rd_at_start && mdl_done) exp_q.push_back(exp_row(2));
    @(posedge clk); #1;
    start = 1'b0; rd_en = 1'b0;
    mdl_done = 1'b0;
    check_b("busy_after_start", busy, 1'b1);
    check_b("done_after_start", done, 1'b0);
    while (k < NCAP && clocks < 400) begin
      if (k == abort_at) begin
        do_reset(1'b1);
        return;
      end
      case (en_mode)
        0:       e = 1'b1;
        1:       e = (clocks % 2 == 0);
        default: e = 1'($urandom_range(0, 1));
      endcase
      en    = e;
      start = (k == start_at);
      rd_en = rd_during;
      crow  = IW'($urandom);
      for (int j = 0; j < DIM; j++) begin
        int r;
        r = k - j;
        if (e && r >= 0 && r < DIM) cin[j] = BITS_C'(mdl_c[r][j]);
        else                        cin[j] = BITS_C'($urandom);
      end
      @(posedge clk); #1;
      clocks++;
      if (e) k++;
      if (k < NCAP) begin
        check_b("busy_in_capture", busy, 1'b1);
        check_b("done_in_capture", done, 1'b0);
      end
    end
    en = 1'b0; start = 1'b0; rd_en = 1'b0;
    check_b("capture_in_budget", clocks < 400, 1'b1);
    check_b("done_after_last_en", done, 1'b1);
    check_b("busy_after_last_en", busy, 1'b0);
    if (en_mode == 0) check_i("capture_clocks", clocks, NCAP);
    if (en_mode == 1) check_i("capture_clocks_alt", clocks, 2 * NCAP - 1);
    mdl_buf  = mdl_c;
    mdl_done = 1'b1;
  endtask

  task automatic read_burst(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      rd_en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      crow  = rnd ? IW'($urandom) : IW'(i);
      if (rd_en && mdl_done) exp_q.push_back(exp_row(int'(crow)));
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
    check_i("read_drain", exp_q.size(), 0);
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl_c[r][c] = 16 * r + c;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; en = 1'b0; rd_en = 1'b0; crow = '0;
    for (int j = 0; j < DIM; j++) cin[j] = '0;
    mdl_done = 1'b0;
    mon_last = '0;

    do_reset(1'b0);
    read_burst(4, 1'b1);

    fill_pattern();
    do_capture(0, -1, -1, 1'b0, 1'b0);
    read_burst(DIM, 1'b0);

    do_capture(1, -1, -1, 1'b0, 1'b0);
    read_burst(DIM, 1'b0);

    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl_c[r][c] = (r == c) ? -8388608 : 8388607;
    do_capture(0, -1, -1, 1'b0, 1'b0);
    read_burst(DIM, 1'b0);

    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) mdl_c[r][c] = int'($urandom);
      do_capture(2, -1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      read_burst(20, 1'b1);
    end

    fill_pattern();
    do_capture(0, 3, -1, 1'b0, 1'b1);
    read_burst(DIM, 1'b0);

    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl_c[r][c] = int'($urandom);
    do_capture(0, -1, -1, 1'b1, 1'b0);
    read_burst(DIM, 1'b0);

    do_capture(0, -1, 6, 1'b0, 1'b0);
    read_burst(3, 1'b1);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl_c[r][c] = 5;
    do_capture(0, -1, -1, 1'b0, 1'b0);
    read_burst(DIM, 1'b0);

    @(posedge clk); #1;
    check_i("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
